matmul_tile_sequencer: RTL and testbench
========================================

Name: matmul_tile_sequencer

Overview:
- Host-side controller for the 16x16 matmul top built from 8x8 systolic tiles.
- Accepts a streamed job and sequences four phases on the array's memory/control ports:
  - load A BRAMs;
  - load B BRAMs;
  - run compute, capture C;
  - unload C rows back to the host with backpressure.
- Sits between the host stream interface and the matrix_multiplication port set; owns every enable, address, write-enable and start signal of the array.

Parameters:
- DWIDTH, 16, element width
- BB_SIZE, 8, elements per memory word
- AWIDTH, 7, memory address width
- LOAD_DEPTH, 16, words written per A and per B load (addresses 0..LOAD_DEPTH-1)
- UNLOAD_DEPTH, 16, words read back from C
- WR_ALIGN, 2, cycles by which we/data lag the address (array registers addr twice, not we/data)
- RD_LAT, 4, cycles from read address out to valid array data in
- DRAIN_CYCLES, 32, cycles we_c stays high after mm_done

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- job_start  in  1  pulse; accepted only in IDLE
- in_valid  in  1  host load word valid
- in_ready  out  1  sequencer accepts load word
- in_data  in  BB_SIZE*DWIDTH  load word (A words first, then B)
- out_valid  out  1  C word valid
- out_ready  in  1  host accepts C word
- out_data  out  BB_SIZE*DWIDTH  C word, ascending address order
- mm_enable_writing  out  1  to enable_writing_to_mem
- mm_enable_reading  out  1  to enable_reading_from_mem
- mm_addr  out  AWIDTH  to addr_pi
- mm_data_pi  out  BB_SIZE*DWIDTH  to data_pi
- mm_we_a / mm_we_b / mm_we_c  out  1 each  write enables
- mm_start  out  1  to start_mat_mul
- mm_done  in  1  from done_mat_mul
- mm_data_out  in  BB_SIZE*DWIDTH  from data_from_out_mat
- busy  out  1  high in any state but IDLE
- job_done  out  1  one-cycle pulse when last C word is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, unload FIFO empty. Reset mid-job aborts immediately with no flush; the next job starts clean.
- States: IDLE -> LOAD_A -> LOAD_B -> WR_FLUSH -> COMPUTE -> DRAIN -> UNLOAD -> IDLE.
- IDLE: job_start=1 -> LOAD_A, addr counter 0. job_start in any other state is ignored.
- LOAD_A / LOAD_B:
  - mm_enable_writing=1; in_ready=1.
  - Each in_valid&in_ready handshake drives mm_addr=counter and increments the counter.
  - The word and mm_we_a (mm_we_b in LOAD_B) are driven exactly WR_ALIGN cycles later through a WR_ALIGN-stage shift pipe.
  - Bubble cycles (in_valid=0) produce we=0 at the aligned slot.
  - After handshake LOAD_DEPTH-1: counter clears; LOAD_A -> LOAD_B, LOAD_B -> WR_FLUSH.
  - mm_addr holds its last value between handshakes.
- WR_FLUSH: WR_ALIGN cycles; mm_enable_writing stays 1 until the pipe empties; in_ready=0.
- COMPUTE:
  - mm_start=1 and mm_we_c=1 every cycle.
  - On mm_done=1 -> DRAIN; mm_start drops the following cycle.
- DRAIN: mm_we_c=1 for DRAIN_CYCLES cycles, then 0 -> UNLOAD.
- UNLOAD:
  - mm_enable_reading=1.
  - Read address issued when credit = FIFO_DEPTH - occupancy - inflight > 0, with FIFO_DEPTH=RD_LAT+2.
  - mm_data_out is captured into the FIFO RD_LAT cycles after issue.
  - out_valid = FIFO not empty; pop on out_valid&out_ready.
  - out_ready=0 indefinitely must never overflow the FIFO or drop data.
  - After the UNLOAD_DEPTH-th pop: job_done pulse, -> IDLE.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Address counters are AWIDTH wide. LOAD_DEPTH and UNLOAD_DEPTH must be <= 2^AWIDTH; wrap is not reachable.

Optional Feature:
- Macro MMSEQ_COMPUTE_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in COMPUTE.
  - Reaching 0xFFFF without mm_done forces state to IDLE, drops mm_start/mm_we_c, and sets sticky output timeout_err (1 bit) until reset or the next job_start.
- When not defined: no counter, no timeout_err port; COMPUTE waits forever.

Test Plan:
- Nominal job, in_valid always 1, out_ready always 1, mm_done modeled 40 cycles after mm_start -> 16 mm_we_a pulses each 2 cycles after mm_addr 0..15, then 16 mm_we_b, then mm_start high 40 cycles, 16 C words out in order, job_done once.
- in_valid toggled 1/0 during LOAD_A -> mm_we_a pulses only on the aligned slots of handshakes, data matches words 0..15, no extra writes.
- out_ready low for 50 cycles at unload start, then 1 -> at most RD_LAT+2 reads issued while stalled, all 16 words delivered, no loss or duplication.
- reset asserted during COMPUTE -> all mm_* outputs 0 asynchronously; fresh job then completes normally.
- job_start pulsed during LOAD_B -> ignored, sequence unchanged.
- With MMSEQ_COMPUTE_TIMEOUT_EN and mm_done never asserted -> after 65535 COMPUTE cycles state is IDLE, timeout_err=1, cleared by the next job_start.

Source files
------------

// File: rtl/matmul_tile_sequencer.sv
// Host-side job sequencer for the 16x16 systolic matmul: load A, load B, compute, drain, unload C.
// Optional compute watchdog and timeout_err port when MMSEQ_COMPUTE_TIMEOUT_EN is defined.
module matmul_tile_sequencer #(
    parameter int DWIDTH       = 16,
    parameter int BB_SIZE      = 8,
    parameter int AWIDTH       = 7,
    parameter int LOAD_DEPTH   = 16,
    parameter int UNLOAD_DEPTH = 16,
    parameter int WR_ALIGN     = 2,
    parameter int RD_LAT       = 4,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      job_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BB_SIZE*DWIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BB_SIZE*DWIDTH-1:0] out_data,
    output logic                      mm_enable_writing,
    output logic                      mm_enable_reading,
    output logic [AWIDTH-1:0]         mm_addr,
    output logic [BB_SIZE*DWIDTH-1:0] mm_data_pi,
    output logic                      mm_we_a,
    output logic                      mm_we_b,
    output logic                      mm_we_c,
    output logic                      mm_start,
    input  logic                      mm_done,
    input  logic [BB_SIZE*DWIDTH-1:0] mm_data_out,
    output logic                      busy,
    output logic                      job_done
`ifdef MMSEQ_COMPUTE_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);
    localparam int WORD_W     = BB_SIZE * DWIDTH;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW         = $clog2(FIFO_DEPTH + 1);
    localparam int DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int CW         = AWIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_WR_FLUSH, S_COMPUTE, S_DRAIN, S_UNLOAD
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     pop_cnt_reg;
    logic [AWIDTH-1:0] addr_hold_reg;
    logic [DW-1:0]     drain_reg;

    logic              wr_v_reg    [WR_ALIGN];
    logic              wr_sel_reg  [WR_ALIGN];
    logic [WORD_W-1:0] wr_data_reg [WR_ALIGN];
    logic [RD_LAT-1:0] rd_v_reg;

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0]     occ_reg, inflight_reg;

    logic ld_hs, last_ld, rd_issue, push, pop, last_pop, timeout_hit;

    assign ld_hs    = in_valid & in_ready;
    assign last_ld  = (cnt_reg == CW'(LOAD_DEPTH - 1));
    // Credit counts reads still in the array pipeline so a stalled host can never overflow the FIFO.
    assign rd_issue = mm_enable_reading && (cnt_reg < CW'(UNLOAD_DEPTH))
                      && ((occ_reg + inflight_reg) < OW'(FIFO_DEPTH));
    assign push     = rd_v_reg[RD_LAT-1];
    assign out_valid = (occ_reg != '0);
    assign pop      = out_valid & out_ready;
    assign last_pop = pop && (pop_cnt_reg == CW'(UNLOAD_DEPTH - 1));
    assign job_done = (state_reg == S_UNLOAD) && last_pop;
    assign busy     = (state_reg != S_IDLE);
    assign mm_addr  = (ld_hs || rd_issue) ? cnt_reg[AWIDTH-1:0] : addr_hold_reg;
    assign out_data = out_valid ? fifo_mem[rd_ptr_reg] : '0;

    assign mm_data_pi = wr_data_reg[WR_ALIGN-1];
    assign mm_we_a    = wr_v_reg[WR_ALIGN-1] & ~wr_sel_reg[WR_ALIGN-1];
    assign mm_we_b    = wr_v_reg[WR_ALIGN-1] &  wr_sel_reg[WR_ALIGN-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (job_start) state_next = S_LOAD_A;
            S_LOAD_A:   if (ld_hs && last_ld) state_next = S_LOAD_B;
            S_LOAD_B:   if (ld_hs && last_ld) state_next = S_WR_FLUSH;
            S_WR_FLUSH: if (cnt_reg == CW'(WR_ALIGN - 1)) state_next = S_COMPUTE;
            S_COMPUTE: begin
                if (mm_done)          state_next = S_DRAIN;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_DRAIN:    if (drain_reg == DW'(DRAIN_CYCLES - 1)) state_next = S_UNLOAD;
            S_UNLOAD:   if (last_pop) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready          = 1'b0;
        mm_enable_writing = 1'b0;
        mm_enable_reading = 1'b0;
        mm_start          = 1'b0;
        mm_we_c           = 1'b0;
        case (state_reg)
            S_LOAD_A, S_LOAD_B: begin
                in_ready          = 1'b1;
                mm_enable_writing = 1'b1;
            end
            S_WR_FLUSH: mm_enable_writing = 1'b1;
            S_COMPUTE: begin
                mm_start = 1'b1;
                mm_we_c  = 1'b1;
            end
            S_DRAIN:  mm_we_c = 1'b1;
            S_UNLOAD: mm_enable_reading = 1'b1;
            default: ;
        endcase
    end

    // One counter serves load addresses, flush timing and read issue; the phases never overlap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            pop_cnt_reg   <= '0;
            addr_hold_reg <= '0;
            drain_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_reg     <= '0;
                    pop_cnt_reg <= '0;
                    drain_reg   <= '0;
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (ld_hs) begin
                        addr_hold_reg <= cnt_reg[AWIDTH-1:0];
                        cnt_reg       <= last_ld ? '0 : cnt_reg + CW'(1);
                    end
                end
                S_WR_FLUSH: cnt_reg <= (cnt_reg == CW'(WR_ALIGN - 1)) ? '0 : cnt_reg + CW'(1);
                S_DRAIN: drain_reg <= (drain_reg == DW'(DRAIN_CYCLES - 1)) ? '0 : drain_reg + DW'(1);
                S_UNLOAD: begin
                    if (rd_issue) begin
                        addr_hold_reg <= cnt_reg[AWIDTH-1:0];
                        cnt_reg       <= cnt_reg + CW'(1);
                    end
                    if (pop) pop_cnt_reg <= pop_cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Write-enable and data trail the address by WR_ALIGN cycles to match the array's address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WR_ALIGN; i++) begin
                wr_v_reg[i]    <= 1'b0;
                wr_sel_reg[i]  <= 1'b0;
                wr_data_reg[i] <= '0;
            end
            rd_v_reg <= '0;
        end else begin
            wr_v_reg[0]    <= ld_hs;
            wr_sel_reg[0]  <= (state_reg == S_LOAD_B);
            wr_data_reg[0] <= in_data;
            for (int i = 1; i < WR_ALIGN; i++) begin
                wr_v_reg[i]    <= wr_v_reg[i-1];
                wr_sel_reg[i]  <= wr_sel_reg[i-1];
                wr_data_reg[i] <= wr_data_reg[i-1];
            end
            rd_v_reg[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) rd_v_reg[i] <= rd_v_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            inflight_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + OW'(1);
                2'b01:   occ_reg <= occ_reg - OW'(1);
                default: ;
            endcase
            case ({rd_issue, push})
                2'b10:   inflight_reg <= inflight_reg + OW'(1);
                2'b01:   inflight_reg <= inflight_reg - OW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= mm_data_out;
    end

`ifdef MMSEQ_COMPUTE_TIMEOUT_EN
    logic [15:0] wd_reg;
    logic        timeout_err_reg;

    // Fires on the cycle the watchdog would reach 0xFFFF, so COMPUTE lasts at most 65535 cycles.
    assign timeout_hit = (state_reg == S_COMPUTE) && !mm_done && (wd_reg == 16'hFFFE);
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_reg          <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wd_reg <= (state_reg == S_COMPUTE) ? wd_reg + 16'd1 : '0;
            if (timeout_hit)                           timeout_err_reg <= 1'b1;
            else if (state_reg == S_IDLE && job_start) timeout_err_reg <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: full jobs with bubbles, backpressure, mid-job reset and stray job_start.
module tb_matmul_tile_sequencer;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         job_start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         mm_enable_writing, mm_enable_reading;
    logic [6:0]   mm_addr;
    logic [W-1:0] mm_data_pi;
    logic         mm_we_a, mm_we_b, mm_we_c, mm_start;
    logic         mm_done = 1'b0;
    logic [W-1:0] mm_data_out;
    logic         busy, job_done;

    int compared = 0;
    int mismatched = 0;

    matmul_tile_sequencer dut (
        .clk(clk), .reset(reset), .job_start(job_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mm_enable_writing(mm_enable_writing), .mm_enable_reading(mm_enable_reading),
        .mm_addr(mm_addr), .mm_data_pi(mm_data_pi),
        .mm_we_a(mm_we_a), .mm_we_b(mm_we_b), .mm_we_c(mm_we_c),
        .mm_start(mm_start), .mm_done(mm_done), .mm_data_out(mm_data_out),
        .busy(busy), .job_done(job_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] make_word(input logic [15:0] base, input int k);
        logic [W-1:0] w;
        for (int e = 0; e < 8; e++) w[e*16 +: 16] = base | 16'(k * 16 + e);
        return w;
    endfunction

    // Array read model: C word at an address appears four cycles after the address.
    logic [6:0] rd_pipe [4];
    always @(posedge clk) begin
        rd_pipe[0] <= mm_addr;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        rd_pipe[3] <= rd_pipe[2];
    end
    assign mm_data_out = make_word(16'hC000, int'(rd_pipe[3]));

    int hs_cnt, we_a_cnt, we_b_cnt, wr_err, start_cycles, we_c_cycles;
    int out_cnt, out_err, jd_cnt, stall_max;
    bit timed_out;
    logic [9:0]   abort_flags;
    logic [6:0]   abort_addr;
    logic [W-1:0] abort_pi;

    task automatic run_job(input bit toggle, input bit stall, input bit abort_mid, input bit start_in_b);
        int idx = 0, rd_cycles = 0, tail = 0;
        bit h1_hs = 0, h2_hs = 0, extra_pulsed = 0, hs;
        logic [6:0] h1_addr = '0, h2_addr = '0;
        hs_cnt = 0; we_a_cnt = 0; we_b_cnt = 0; wr_err = 0; start_cycles = 0; we_c_cycles = 0;
        out_cnt = 0; out_err = 0; jd_cnt = 0; stall_max = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            job_start = (cyc == 0) || (start_in_b && idx == 20 && !extra_pulsed);
            if (start_in_b && idx == 20) extra_pulsed = 1'b1;
            in_valid  = (idx < 32) && (!toggle || (cyc % 2 == 0));
            in_data   = (idx < 16) ? make_word(16'hA000, idx) :
                        (idx < 32) ? make_word(16'hB000, idx - 16) : '0;
            out_ready = !(stall && rd_cycles < 50);
            mm_done   = mm_start && (start_cycles == 39);
            if (abort_mid && mm_start && start_cycles == 10) begin
                reset = 1'b0;
                #1;
                abort_flags = {mm_enable_writing, mm_enable_reading, mm_we_a, mm_we_b, mm_we_c,
                               mm_start, busy, in_ready, out_valid, job_done};
                abort_addr  = mm_addr;
                abort_pi    = mm_data_pi;
                job_start = 1'b0; in_valid = 1'b0; mm_done = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                timed_out = 1'b0;
                $display("job: aborted by reset after %0d compute cycles", start_cycles);
                return;
            end
            #1;
            if (mm_start) start_cycles++;
            if (mm_we_c) we_c_cycles++;
            if (mm_enable_reading) rd_cycles++;
            if (!out_ready && mm_enable_reading && int'(mm_addr) > stall_max) stall_max = int'(mm_addr);
            if (mm_we_a) begin
                if (!(h2_hs && int'(h2_addr) == we_a_cnt && we_b_cnt == 0 && mm_enable_writing
                      && mm_data_pi === make_word(16'hA000, we_a_cnt))) wr_err++;
                we_a_cnt++;
            end
            if (mm_we_b) begin
                if (!(h2_hs && int'(h2_addr) == we_b_cnt && we_a_cnt == 16 && mm_enable_writing
                      && mm_data_pi === make_word(16'hB000, we_b_cnt))) wr_err++;
                we_b_cnt++;
            end
            if ((mm_we_a && mm_we_b) || (h2_hs && !(mm_we_a || mm_we_b))) wr_err++;
            hs = in_valid && in_ready;
            if (hs) begin hs_cnt++; idx++; end
            h2_hs = h1_hs; h2_addr = h1_addr;
            h1_hs = hs;    h1_addr = mm_addr;
            if (out_valid && out_ready) begin
                if (out_data !== make_word(16'hC000, out_cnt)) out_err++;
                out_cnt++;
            end
            if (job_done) begin
                jd_cnt++;
                if (out_cnt != 16) out_err++;
            end
            if (jd_cnt > 0) begin
                tail++;
                if (tail == 4) begin timed_out = 1'b0; break; end
            end
        end
        job_start = 1'b0; in_valid = 1'b0; mm_done = 1'b0; out_ready = 1'b0;
        $display("job: hs=%0d we_a=%0d we_b=%0d start_cycles=%0d we_c_cycles=%0d c_words=%0d job_done=%0d",
                 hs_cnt, we_a_cnt, we_b_cnt, start_cycles, we_c_cycles, out_cnt, jd_cnt);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({busy, in_ready, out_valid, mm_start, mm_we_c, mm_we_a, mm_we_b, job_done} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b need 00000000",
                     {busy, in_ready, out_valid, mm_start, mm_we_c, mm_we_a, mm_we_b, job_done});
        end
        compared++;
        if (mm_addr !== 7'd0) begin mismatched++; $display("FAIL reset_addr: got %0d need 0", mm_addr); end
        compared++;
        if ({mm_enable_writing, mm_enable_reading} !== 2'b00) begin
            mismatched++; $display("FAIL reset_enables: got %b need 00", {mm_enable_writing, mm_enable_reading});
        end
        compared++;
        if (mm_data_pi !== '0 || out_data !== '0) begin
            mismatched++; $display("FAIL reset_data: got pi=%h out=%h need 0", mm_data_pi, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_nominal();
        run_job(1'b0, 1'b0, 1'b0, 1'b0);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL nominal_finish: got timeout need job_done"); end
        compared++;
        if (we_a_cnt != 16 || we_b_cnt != 16) begin
            mismatched++; $display("FAIL nominal_we_count: got a=%0d b=%0d need 16/16", we_a_cnt, we_b_cnt);
        end
        compared++;
        if (wr_err != 0) begin mismatched++; $display("FAIL nominal_write_align: got %0d bad writes need 0", wr_err); end
        compared++;
        if (start_cycles != 40) begin mismatched++; $display("FAIL nominal_start_cycles: got %0d need 40", start_cycles); end
        compared++;
        if (we_c_cycles != 72) begin mismatched++; $display("FAIL nominal_we_c_cycles: got %0d need 72", we_c_cycles); end
        compared++;
        if (out_cnt != 16 || out_err != 0) begin
            mismatched++; $display("FAIL nominal_c_words: got %0d words %0d bad need 16/0", out_cnt, out_err);
        end
        compared++;
        if (jd_cnt != 1) begin mismatched++; $display("FAIL nominal_job_done: got %0d pulses need 1", jd_cnt); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL nominal_idle: got busy=%b need 0", busy); end
    endtask

    task automatic test_bubbles();
        run_job(1'b1, 1'b0, 1'b0, 1'b0);
        compared++;
        if (hs_cnt != 32) begin mismatched++; $display("FAIL bubble_handshakes: got %0d need 32", hs_cnt); end
        compared++;
        if (we_a_cnt != 16 || we_b_cnt != 16) begin
            mismatched++; $display("FAIL bubble_we_count: got a=%0d b=%0d need 16/16", we_a_cnt, we_b_cnt);
        end
        compared++;
        if (wr_err != 0) begin mismatched++; $display("FAIL bubble_write_align: got %0d bad writes need 0", wr_err); end
        compared++;
        if (out_cnt != 16 || out_err != 0 || jd_cnt != 1) begin
            mismatched++; $display("FAIL bubble_c_words: got %0d words %0d bad %0d done need 16/0/1", out_cnt, out_err, jd_cnt);
        end
    endtask

    task automatic test_backpressure();
        run_job(1'b0, 1'b1, 1'b0, 1'b0);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL stall_finish: got timeout need job_done"); end
        compared++;
        if (stall_max != 5) begin mismatched++; $display("FAIL stall_reads: got max addr %0d need 5", stall_max); end
        compared++;
        if (out_cnt != 16 || out_err != 0) begin
            mismatched++; $display("FAIL stall_c_words: got %0d words %0d bad need 16/0", out_cnt, out_err);
        end
        compared++;
        if (jd_cnt != 1) begin mismatched++; $display("FAIL stall_job_done: got %0d pulses need 1", jd_cnt); end
    endtask

    task automatic test_reset_mid_compute();
        run_job(1'b0, 1'b0, 1'b1, 1'b0);
        compared++;
        if (abort_flags !== 10'b0) begin mismatched++; $display("FAIL abort_ctrl: got %b need all 0", abort_flags); end
        compared++;
        if (abort_addr !== 7'd0) begin mismatched++; $display("FAIL abort_addr: got %0d need 0", abort_addr); end
        compared++;
        if (abort_pi !== '0) begin mismatched++; $display("FAIL abort_data_pi: got %h need 0", abort_pi); end
        run_job(1'b0, 1'b0, 1'b0, 1'b0);
        compared++;
        if (timed_out || out_cnt != 16 || out_err != 0 || jd_cnt != 1 || wr_err != 0) begin
            mismatched++;
            $display("FAIL abort_rerun: got words=%0d bad=%0d done=%0d wr_err=%0d timeout=%0b need 16/0/1/0/0",
                     out_cnt, out_err, jd_cnt, wr_err, timed_out);
        end
    endtask

    task automatic test_start_in_load_b();
        run_job(1'b0, 1'b0, 1'b0, 1'b1);
        compared++;
        if (hs_cnt != 32 || we_a_cnt != 16 || we_b_cnt != 16 || wr_err != 0) begin
            mismatched++;
            $display("FAIL stray_start_load: got hs=%0d a=%0d b=%0d err=%0d need 32/16/16/0",
                     hs_cnt, we_a_cnt, we_b_cnt, wr_err);
        end
        compared++;
        if (start_cycles != 40) begin mismatched++; $display("FAIL stray_start_compute: got %0d need 40", start_cycles); end
        compared++;
        if (out_cnt != 16 || out_err != 0 || jd_cnt != 1) begin
            mismatched++; $display("FAIL stray_start_unload: got %0d words %0d bad %0d done need 16/0/1", out_cnt, out_err, jd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bubbles();
        test_backpressure();
        test_reset_mid_compute();
        test_start_in_load_b();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
